// File: rtl/mac_sim_pkg.sv
// mac_sim_pkg: shared state encoding, LFSR polynomial and framing helpers for the MAC RX packet source.
package mac_sim_pkg;
  typedef enum logic [2:0] {IDLE, AVAIL, READ, HALT, GAP, DONE} state_t;
  // Right-shift Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction
  function automatic int ben_calc(input int len, input int bytes_per_beat);
    return (len - 1) % bytes_per_beat;
  endfunction
endpackage

// File: rtl/mac_lfsr32.sv
// mac_lfsr32: 32-bit Galois LFSR advancing STEPS states per enabled cycle.
module mac_lfsr32
  import mac_sim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001,
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  output logic [31:0] state
);
  logic [31:0] nxt;
  always_comb begin
    nxt = state;
    for (int i = 0; i < STEPS; i++) nxt = lfsr_step(nxt);
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= SEED;
    else if (en) state <= nxt;
  end
endmodule

// File: rtl/mac_rx_pkt_gen.sv
// mac_rx_pkt_gen: MAC RX packet source emitting framed LFSR data with halts and inter-packet gaps.
module mac_rx_pkt_gen
  import mac_sim_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BEN_W = 2,
  parameter int LEN_W = 16,
  parameter int HALT_PERIOD = 10000,
  parameter int HALT_LEN = 55,
  parameter int IPG = 12,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic              mac_clk_i,
  input  logic              mac_rstn_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  pkt_len_i,
  input  logic [LEN_W-1:0]  pkt_cnt_i,
  input  logic              stop_i,
  input  logic              mac_rxrqrd_i,
  output logic [DATA_W-1:0] mac_rxd_o,
  output logic [BEN_W-1:0]  mac_ben_o,
  output logic              mac_rxda_o,
  output logic              mac_rxsop_o,
  output logic              mac_rxeop_o,
  output logic              mac_rxdv_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  pkts_sent_o
);
  localparam int BYTES = DATA_W / 8;
  localparam int NW = (DATA_W + 31) / 32;
  localparam bit HALT_EN = HALT_PERIOD != 0 && HALT_LEN != 0;
  localparam int HP = HALT_PERIOD == 0 ? 1 : HALT_PERIOD;
  localparam int HW = $clog2(HALT_LEN + 2);
  localparam int GW = $clog2(IPG + 2);
  state_t state, next;
  logic [LEN_W-1:0] len_cfg, cnt_cfg, beat_cnt, pkt_idx, last_idx;
  logic [HW-1:0] halt_cnt;
  logic [GW-1:0] gap_cnt;
  logic [BEN_W-1:0] ben_v;
  logic [31:0] lfsr, s;
  logic [NW*32-1:0] words;
  logic [DATA_W-1:0] mask;
  logic start_ok, xfer, last, halt_due, last_pkt, fin, stop_seen;
  mac_lfsr32 #(.SEED(LFSR_SEED), .STEPS(NW)) u_lfsr (
    .clk(mac_clk_i), .rstn(mac_rstn_i), .en(xfer), .state(lfsr)
  );
  // Wide buses take successive LFSR states, oldest in the low word
  always_comb begin
    s = lfsr;
    words = '0;
    for (int j = 0; j < NW; j++) begin
      words[32*j +: 32] = s;
      s = lfsr_step(s);
    end
  end
  always_comb begin
    mask = '0;
    for (int i = 0; i < BYTES; i++) mask[8*i +: 8] = (!last || i <= int'(ben_v)) ? 8'hFF : 8'h00;
  end
  assign last_idx = LEN_W'((int'(len_cfg) - 1) / BYTES);
  assign ben_v = BEN_W'(ben_calc(int'(len_cfg), BYTES));
  assign start_ok = start_i && (state == IDLE || state == DONE);
  assign xfer = state == READ && mac_rxrqrd_i;
  assign last = beat_cnt == last_idx;
  assign halt_due = HALT_EN && !last && (int'(beat_cnt) + 1) % HP == 0;
  assign last_pkt = cnt_cfg != '0 && int'(pkt_idx) + 1 >= int'(cnt_cfg);
  assign fin = stop_seen || stop_i;
  assign busy_o = state != IDLE && state != DONE;
  assign done_o = state == DONE;
  // Packet-available stays up through the eop beat itself
  assign mac_rxda_o = state == AVAIL || state == READ || state == HALT || mac_rxeop_o;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start_i ? AVAIL : state;
      AVAIL: next = fin ? DONE : mac_rxrqrd_i ? READ : AVAIL;
      READ: next = !xfer ? READ : last ? (IPG != 0 ? GAP : (fin || last_pkt) ? DONE : AVAIL) : halt_due ? HALT : READ;
      HALT: next = halt_cnt == HW'(HALT_LEN - 1) ? READ : HALT;
      GAP: next = gap_cnt == GW'(IPG) ? (fin ? DONE : AVAIL) : GAP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge mac_clk_i) begin
    if (!mac_rstn_i) begin
      state <= IDLE;
      len_cfg <= '0;
      cnt_cfg <= '0;
      beat_cnt <= '0;
      pkt_idx <= '0;
      halt_cnt <= '0;
      gap_cnt <= '0;
      stop_seen <= 1'b0;
      mac_rxd_o <= '0;
      mac_ben_o <= '0;
      mac_rxsop_o <= 1'b0;
      mac_rxeop_o <= 1'b0;
      mac_rxdv_o <= 1'b0;
      pkts_sent_o <= '0;
    end else begin
      state <= next;
      halt_cnt <= state == HALT ? halt_cnt + 1'b1 : '0;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
      mac_rxdv_o <= xfer;
      mac_rxsop_o <= xfer && beat_cnt == '0;
      mac_rxeop_o <= xfer && last;
      if (xfer) begin
        mac_rxd_o <= words[DATA_W-1:0] & mask;
        mac_ben_o <= last ? ben_v : '1;
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      end
      if (mac_rxeop_o && pkts_sent_o != '1) pkts_sent_o <= pkts_sent_o + 1'b1;
      if (start_ok) begin
        len_cfg <= pkt_len_i == '0 ? LEN_W'(1) : pkt_len_i;
        cnt_cfg <= pkt_cnt_i;
        pkt_idx <= '0;
        beat_cnt <= '0;
        pkts_sent_o <= '0;
        stop_seen <= 1'b0;
      end else if (busy_o) begin
        stop_seen <= fin || (xfer && last && last_pkt);
        if (xfer && last) pkt_idx <= pkt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mac_rx_pkt_gen.sv
// tb_mac_rx_pkt_gen: randomized and directed checks of mac_rx_pkt_gen against a beat-level reference model.
module tb_mac_rx_pkt_gen;
  localparam int DW = 32, LW = 16, HPER = 8, HLEN = 5, GAPC = 12;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, stop = 1'b0, rq = 1'b0;
  logic [LW-1:0] len_i = '0, cnt_i = '0;
  logic [DW-1:0] rxd;
  logic [1:0] ben;
  logic rxda, sop, eop, dv, busy, done;
  logic [LW-1:0] sent;
  int vectors = 0, errors = 0;
  int rq_mode = 0, cfg_len = 1;
  bit exp_accept = 0;
  logic [31:0] m_lfsr = SEED, first_data = '0, second_data = '0, last_data = '0;
  logic [1:0] last_ben = '0;
  logic last_sop = 1'b0;
  int m_idx = 0, m_sent = 0, quiet = 0, low_run = 0, halt_low = 0, gap_cnt = 0, beats_seen = 0;
  bit gap_arm = 0, rst_prev = 0, prev_rq = 0;
  always #5 clk = ~clk;
  mac_rx_pkt_gen #(.DATA_W(DW), .BEN_W(2), .LEN_W(LW), .HALT_PERIOD(HPER), .HALT_LEN(HLEN),
    .IPG(GAPC), .LFSR_SEED(SEED)) dut (
    .mac_clk_i(clk), .mac_rstn_i(rstn), .start_i(start), .pkt_len_i(len_i), .pkt_cnt_i(cnt_i),
    .stop_i(stop), .mac_rxrqrd_i(rq), .mac_rxd_o(rxd), .mac_ben_o(ben), .mac_rxda_o(rxda),
    .mac_rxsop_o(sop), .mac_rxeop_o(eop), .mac_rxdv_o(dv), .busy_o(busy), .done_o(done),
    .pkts_sent_o(sent)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // One division step by x^32+x^22+x^2+x+1, shifting towards bit 0
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] poly;
    poly = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;
    return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
  endfunction
  always @(posedge clk) begin
    #1;
    rq = rq_mode == 1 ? 1'b1 : rq_mode == 2 ? ~rq : rq_mode == 3 ? 1'($urandom % 2) : 1'b0;
  end
  always @(negedge clk) begin
    int nb, nbytes;
    bit is_eop, inc;
    logic [31:0] bmask;
    inc = 0;
    if (!rst_prev) begin
      chk("reset_outputs", {rxd, ben, rxda, sop, eop, dv, busy, done, sent}, 0);
      m_lfsr = SEED;
      m_idx = 0;
      m_sent = 0;
      quiet = 0;
      gap_arm = 0;
      low_run = 0;
      beats_seen = 0;
    end else begin
      if (quiet > 0) begin
        chk("halt_dv_low", dv, 0);
        quiet--;
      end
      if (dv) begin
        nb = (cfg_len + 3) / 4;
        is_eop = m_idx == nb - 1;
        nbytes = is_eop ? (cfg_len - 1) % 4 + 1 : 4;
        bmask = nbytes == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
        chk("rq_before_dv", prev_rq, 1);
        chk("rxd", rxd, m_lfsr & bmask);
        chk("ben", ben, nbytes - 1);
        chk("sop", sop, m_idx == 0);
        chk("eop", eop, is_eop);
        chk("rxda_beat", rxda, 1);
        if (beats_seen == 0) first_data = rxd;
        if (beats_seen == 1) second_data = rxd;
        if (m_idx == 8) halt_low = low_run;
        if (is_eop) begin
          last_data = rxd;
          last_ben = ben;
          last_sop = sop;
        end
        beats_seen++;
        low_run = 0;
        m_lfsr = lfsr_next(m_lfsr);
        m_idx++;
        if (is_eop) begin
          m_idx = 0;
          inc = 1;
          gap_arm = 1;
          gap_cnt = 0;
        end else if (m_idx % HPER == 0) quiet = HLEN;
      end else begin
        chk("idle_sop_eop", {sop, eop}, 0);
        low_run++;
      end
      chk("pkts_sent", sent, m_sent);
      if (inc) m_sent++;
      if (gap_arm && !inc) begin
        if (!rxda) gap_cnt++;
        else begin
          chk("ipg_len", gap_cnt, GAPC);
          gap_arm = 0;
        end
      end
      if (start && exp_accept) begin
        m_sent = 0;
        gap_arm = 0;
        beats_seen = 0;
        m_idx = 0;
      end
    end
    rst_prev = rstn;
    prev_rq = rq;
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_seq(input int len, input int cnt, input bit acc);
    len_i = LW'(len);
    cnt_i = LW'(cnt);
    start = 1'b1;
    exp_accept = acc;
    if (acc) cfg_len = len == 0 ? 1 : len;
    cyc(1);
    start = 1'b0;
    exp_accept = 0;
  endtask
  task automatic wait_done(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (done) break;
      cyc(1);
    end
    chk(name, {done, busy}, 2'b10);
  endtask
  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask
  initial begin
    int len, cnt;
    cyc(3);
    rstn = 1'b1;
    cyc(2);
    rq_mode = 1;
    start_seq(64, 1, 1);
    wait_done("t64_done", 300);
    chk("t64_pkts", sent, 1);
    chk("t64_beats", beats_seen, 16);
    chk("t64_first", first_data, 32'hACE1_0001);
    chk("t64_second", second_data, 32'hD650_8003);
    chk("t64_ben", last_ben, 3);
    chk("t64_halt_gap", halt_low, 5);
    start_seq(61, 1, 1);
    wait_done("t61_done", 300);
    chk("t61_beats", beats_seen, 16);
    chk("t61_ben", last_ben, 0);
    chk("t61_upper", last_data[31:8], 0);
    start_seq(1, 1, 1);
    wait_done("t1_done", 100);
    chk("t1_beats", beats_seen, 1);
    chk("t1_sop_eop", last_sop, 1);
    chk("t1_ben", last_ben, 0);
    start_seq(0, 1, 1);
    wait_done("t0_done", 100);
    chk("t0_beats", beats_seen, 1);
    rq_mode = 2;
    start_seq(40, 2, 1);
    wait_done("toggle_done", 600);
    chk("toggle_beats", beats_seen, 20);
    chk("toggle_pkts", sent, 2);
    rq_mode = 1;
    start_seq(20, 3, 1);
    wait_done("cnt3_done", 600);
    chk("cnt3_pkts", sent, 3);
    chk("cnt3_beats", beats_seen, 15);
    start_seq(32, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if (beats_seen >= 10) break;
      cyc(1);
    end
    chk("stop_reach_pkt2", beats_seen >= 10, 1);
    pulse_stop();
    wait_done("stop_done", 300);
    chk("stop_pkts", sent, 2);
    chk("stop_beats", beats_seen, 16);
    start_seq(24, 2, 1);
    cyc(4);
    start_seq(7, 1, 0);
    wait_done("busy_start_done", 400);
    chk("busy_start_pkts", sent, 2);
    chk("busy_start_beats", beats_seen, 12);
    rq_mode = 0;
    start_seq(16, 0, 1);
    cyc(2);
    chk("avail_wait", {rxda, busy}, 2'b11);
    pulse_stop();
    wait_done("avail_stop_done", 20);
    chk("avail_stop_beats", beats_seen, 0);
    chk("avail_stop_pkts", sent, 0);
    rq_mode = 1;
    start_seq(64, 1, 1);
    for (int i = 0; i < 100; i++) begin
      if (beats_seen >= 5) break;
      cyc(1);
    end
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
    chk("post_reset_idle", {done, busy, rxda}, 3'b000);
    start_seq(64, 1, 1);
    wait_done("reseed_done", 300);
    chk("reseed_first", first_data, 32'hACE1_0001);
    chk("reseed_beats", beats_seen, 16);
    rq_mode = 3;
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(1, 70);
      cnt = $urandom_range(1, 3);
      start_seq(len, cnt, 1);
      wait_done("rand_done", 4000);
      chk("rand_pkts", sent, cnt);
      chk("rand_beats", beats_seen, cnt * ((len + 3) / 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
